// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM states,
// requester identifiers and the memory direction encoding.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_t;

  // Same meaning as the controller's mrw line.
  localparam logic MEM_WRITE = 1'b1;
  localparam logic MEM_READ  = 1'b0;

  // Wait counter width; covers the legal WAIT range 0..15.
  localparam int CNT_W = 4;

  // The requester that did not win last time.
  function automatic req_id_t other_req(input req_id_t id);
    req_id_t res;
    if (id == REQ_CPU) begin
      res = REQ_DMA;
    end else begin
      res = REQ_CPU;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the CPU, DMA and memory-side signals of the arbiter.
// master: the arbiter's view (drives memory controls and acks).
// slave:  the environment's view (requesters and memory block).
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;

  logic          mem_en;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          grant_dma;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    output mem_en, mem_rw, mem_addr, mem_wdata, grant_dma
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    input  mem_en, mem_rw, mem_addr, mem_wdata, grant_dma
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational 2-way round-robin picker: a lone request wins outright,
// a tie goes to whichever requester was not served last.
module rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic    cpu_req,
  input  logic    dma_req,
  input  req_id_t last,
  output logic    valid,
  output req_id_t winner
);

  // Select the winner from the current requests and the last owner.
  always_comb begin
    valid  = cpu_req | dma_req;
    winner = REQ_CPU;
    if (cpu_req && dma_req) begin
      winner = other_req(last);
    end else if (dma_req) begin
      winner = REQ_DMA;
    end else begin
      winner = REQ_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between the CPU and DMA requesters.
// Each granted access holds mem_en for WAIT+1 cycles, then a one-cycle
// ack is returned in RESP together with any captured read data.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW   = 16,
  parameter int DW   = 16,
  parameter int WAIT = 2
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.master bus
);

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);

  state_t           state_r,     state_s;
  logic [CNT_W-1:0] cnt_r,       cnt_s;
  req_id_t          last_r,      last_s;
  logic             mem_en_r,    mem_en_s;
  logic             mem_rw_r,    mem_rw_s;
  logic [AW-1:0]    mem_addr_r,  mem_addr_s;
  logic [DW-1:0]    mem_wdata_r, mem_wdata_s;
  logic             cpu_ack_r,   cpu_ack_s;
  logic             dma_ack_r,   dma_ack_s;
  logic [DW-1:0]    cpu_rdata_r, cpu_rdata_s;
  logic [DW-1:0]    dma_rdata_r, dma_rdata_s;
  logic             grant_dma_r, grant_dma_s;

  logic             pick_valid_s;
  req_id_t          pick_winner_s;

  rr_pick u_pick (
    .cpu_req (bus.cpu_req),
    .dma_req (bus.dma_req),
    .last    (last_r),
    .valid   (pick_valid_s),
    .winner  (pick_winner_s)
  );

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    last_s      = last_r;
    mem_en_s    = mem_en_r;
    mem_rw_s    = mem_rw_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    cpu_ack_s   = 1'b0;
    dma_ack_s   = 1'b0;
    cpu_rdata_s = cpu_rdata_r;
    dma_rdata_s = dma_rdata_r;
    grant_dma_s = grant_dma_r;

    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          if (pick_winner_s == REQ_DMA) begin
            mem_rw_s    = bus.dma_we;
            mem_addr_s  = bus.dma_addr;
            mem_wdata_s = bus.dma_wdata;
            grant_dma_s = 1'b1;
          end else begin
            mem_rw_s    = bus.cpu_we;
            mem_addr_s  = bus.cpu_addr;
            mem_wdata_s = bus.cpu_wdata;
            grant_dma_s = 1'b0;
          end
          mem_en_s = 1'b1;
          cnt_s    = WAIT_CNT;
          last_s   = pick_winner_s;
          state_s  = ACCESS;
        end else begin
          mem_en_s = 1'b0;
        end
      end

      ACCESS: begin
        if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          if (mem_rw_r == MEM_READ) begin
            if (last_r == REQ_DMA) begin
              dma_rdata_s = bus.mem_rdata;
            end else begin
              cpu_rdata_s = bus.mem_rdata;
            end
          end else begin
            cpu_rdata_s = cpu_rdata_r;
          end
          if (last_r == REQ_DMA) begin
            dma_ack_s = 1'b1;
          end else begin
            cpu_ack_s = 1'b1;
          end
          mem_en_s = 1'b0;
          mem_rw_s = MEM_READ;
          state_s  = RESP;
        end
      end

      RESP: begin
        grant_dma_s = 1'b0;
        state_s     = IDLE;
      end

      default: begin
        mem_en_s    = 1'b0;
        mem_rw_s    = MEM_READ;
        grant_dma_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous reset aborts any access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      last_r      <= REQ_DMA;
      mem_en_r    <= 1'b0;
      mem_rw_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      cpu_ack_r   <= 1'b0;
      dma_ack_r   <= 1'b0;
      cpu_rdata_r <= {DW{1'b0}};
      dma_rdata_r <= {DW{1'b0}};
      grant_dma_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      last_r      <= last_s;
      mem_en_r    <= mem_en_s;
      mem_rw_r    <= mem_rw_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      cpu_ack_r   <= cpu_ack_s;
      dma_ack_r   <= dma_ack_s;
      cpu_rdata_r <= cpu_rdata_s;
      dma_rdata_r <= dma_rdata_s;
      grant_dma_r <= grant_dma_s;
    end
  end

  assign bus.mem_en    = mem_en_r;
  assign bus.mem_rw    = mem_rw_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.cpu_ack   = cpu_ack_r;
  assign bus.dma_ack   = dma_ack_r;
  assign bus.cpu_rdata = cpu_rdata_r;
  assign bus.dma_rdata = dma_rdata_r;
  assign bus.grant_dma = grant_dma_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table for a CPU read
// and a DMA write, plus hand-written sequences for contention, WAIT=0,
// reset mid-access and a request dropped during an access.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  logic reset0;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) bus0 ();

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT(0)) dut0 (
    .clk   (clk),
    .reset (reset0),
    .bus   (bus0.master)
  );

  always #5 clk = ~clk;

  // Memory model: data depends on address, and is garbage when not enabled.
  assign bus.mem_rdata  = bus.mem_en  ? (bus.mem_addr  ^ 16'hC210) : 16'hDEAD;
  assign bus0.mem_rdata = bus0.mem_en ? (bus0.mem_addr ^ 16'hC210) : 16'hDEAD;

  typedef struct {
    logic        cr, cw;
    logic [15:0] ca, cd;
    logic        dr, dw;
    logic [15:0] da, dd;
    logic        en, rw;
    logic [15:0] ad, wd;
    logic        ck, dk, gd;
    logic [15:0] crd, drd;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
    input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd,
    input logic en, input logic rw, input logic [15:0] ad, input logic [15:0] wd,
    input logic ck, input logic dk, input logic gd,
    input logic [15:0] crd, input logic [15:0] drd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.en = en; v.rw = rw; v.ad = ad; v.wd = wd;
    v.ck = ck; v.dk = dk; v.gd = gd; v.crd = crd; v.drd = drd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_en"},    {31'd0, bus.mem_en},    32'd0);
    check({tag, " mem_rw"},    {31'd0, bus.mem_rw},    32'd0);
    check({tag, " mem_addr"},  {16'd0, bus.mem_addr},  32'd0);
    check({tag, " mem_wdata"}, {16'd0, bus.mem_wdata}, 32'd0);
    check({tag, " acks"},      {30'd0, bus.cpu_ack, bus.dma_ack}, 32'd0);
    check({tag, " grant_dma"}, {31'd0, bus.grant_dma}, 32'd0);
    check({tag, " cpu_rdata"}, {16'd0, bus.cpu_rdata}, 32'd0);
    check({tag, " dma_rdata"}, {16'd0, bus.dma_rdata}, 32'd0);
  endtask

  task automatic idle_inputs();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 16'h0000;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 16'h0000; bus.dma_wdata = 16'h0000;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Global time limit so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int en_cnt;
    int ack_cnt;
    logic exp_dma;

    idle_inputs();
    bus0.cpu_req = 1'b0; bus0.cpu_we = 1'b0; bus0.cpu_addr = 16'h0000; bus0.cpu_wdata = 16'h0000;
    bus0.dma_req = 1'b0; bus0.dma_we = 1'b0; bus0.dma_addr = 16'h0000; bus0.dma_wdata = 16'h0000;
    reset  = 1'b0;
    reset0 = 1'b0;
    #12;
    check_all_zero("reset");
    check("reset0 mem_en", {31'd0, bus0.mem_en}, 32'd0);

    //           cr    cw    ca        cd        dr    dw    da        dd        en    rw    addr      wdata     ck    dk    gd    crd       drd
    vecs[0]  = mk(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    vecs[1]  = mk(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    vecs[2]  = mk(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    vecs[3]  = mk(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hC200, 16'h0000);
    vecs[4]  = mk(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hC200, 16'h0000);
    vecs[5]  = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hC200, 16'h0000);
    vecs[6]  = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'hC200, 16'h0000);
    vecs[7]  = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'hC200, 16'h0000);
    vecs[8]  = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'hC200, 16'h0000);
    vecs[9]  = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 1'b0, 16'h0100, 16'hBEEF, 1'b0, 1'b1, 1'b1, 16'hC200, 16'h0000);
    vecs[10] = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0100, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'hC200, 16'h0000);

    @(negedge clk);
    reset  = 1'b1;
    reset0 = 1'b1;

    // Table: CPU read then DMA write, one vector per clock.
    for (int i = 0; i < 11; i++) begin
      bus.cpu_req = vecs[i].cr; bus.cpu_we = vecs[i].cw; bus.cpu_addr = vecs[i].ca; bus.cpu_wdata = vecs[i].cd;
      bus.dma_req = vecs[i].dr; bus.dma_we = vecs[i].dw; bus.dma_addr = vecs[i].da; bus.dma_wdata = vecs[i].dd;
      step();
      check($sformatf("v%0d mem_en", i),    {31'd0, bus.mem_en},    {31'd0, vecs[i].en});
      check($sformatf("v%0d mem_rw", i),    {31'd0, bus.mem_rw},    {31'd0, vecs[i].rw});
      check($sformatf("v%0d mem_addr", i),  {16'd0, bus.mem_addr},  {16'd0, vecs[i].ad});
      check($sformatf("v%0d mem_wdata", i), {16'd0, bus.mem_wdata}, {16'd0, vecs[i].wd});
      check($sformatf("v%0d cpu_ack", i),   {31'd0, bus.cpu_ack},   {31'd0, vecs[i].ck});
      check($sformatf("v%0d dma_ack", i),   {31'd0, bus.dma_ack},   {31'd0, vecs[i].dk});
      check($sformatf("v%0d grant_dma", i), {31'd0, bus.grant_dma}, {31'd0, vecs[i].gd});
      check($sformatf("v%0d cpu_rdata", i), {16'd0, bus.cpu_rdata}, {16'd0, vecs[i].crd});
      check($sformatf("v%0d dma_rdata", i), {16'd0, bus.dma_rdata}, {16'd0, vecs[i].drd});
    end

    // Contention right after reset: CPU, DMA, CPU, DMA.
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0020;
    bus.dma_req = 1'b1; bus.dma_addr = 16'h0200;
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      exp_dma = n[0];
      cyc = 0;
      do begin
        step();
        cyc++;
      end while (!(bus.cpu_ack || bus.dma_ack) && cyc < 20);
      check($sformatf("tie%0d latency", n), cyc, 32'd4);
      check($sformatf("tie%0d acks", n), {30'd0, bus.cpu_ack, bus.dma_ack},
            exp_dma ? 32'd1 : 32'd2);
      check($sformatf("tie%0d grant_dma", n), {31'd0, bus.grant_dma}, {31'd0, exp_dma});
      check($sformatf("tie%0d mem_addr", n), {16'd0, bus.mem_addr},
            exp_dma ? 32'h0200 : 32'h0020);
      if (exp_dma) begin
        check($sformatf("tie%0d dma_rdata", n), {16'd0, bus.dma_rdata}, 32'hC010);
      end else begin
        check($sformatf("tie%0d cpu_rdata", n), {16'd0, bus.cpu_rdata}, 32'hC230);
      end
      step();
      check($sformatf("tie%0d ack pulse", n), {30'd0, bus.cpu_ack, bus.dma_ack}, 32'd0);
    end
    idle_inputs();
    step();
    step();
    check("tie idle mem_en", {31'd0, bus.mem_en}, 32'd0);

    // WAIT=0 instance: back-to-back CPU reads with cpu_req held.
    bus0.cpu_req = 1'b1; bus0.cpu_addr = 16'h0030;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!bus0.cpu_ack && cyc < 20);
    check("w0 first latency", cyc, 32'd2);
    check("w0 cpu_rdata", {16'd0, bus0.cpu_rdata}, 32'hC220);
    for (int n = 0; n < 3; n++) begin
      cyc = 0;
      en_cnt = 0;
      do begin
        step();
        cyc++;
        if (bus0.mem_en) en_cnt++;
      end while (!bus0.cpu_ack && cyc < 20);
      check($sformatf("w0 ack spacing %0d", n), cyc, 32'd3);
      check($sformatf("w0 mem_en cycles %0d", n), en_cnt, 32'd1);
    end
    bus0.cpu_req = 1'b0;

    // Reset in the 2nd ACCESS cycle of a DMA write, then a fresh access.
    pulse_reset();
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h0300; bus.dma_wdata = 16'h1234;
    step();
    check("rst mid first access", {31'd0, bus.mem_en}, 32'd1);
    step();
    check("rst mid second access", {15'd0, bus.mem_en, bus.mem_wdata}, 32'h11234);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("rst mid");
    ack_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.dma_ack) ack_cnt++;
    end
    check("rst mid no ack", ack_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    en_cnt = 0;
    do begin
      step();
      cyc++;
      if (bus.mem_en) en_cnt++;
    end while (!bus.dma_ack && cyc < 20);
    check("rst retry latency", cyc, 32'd4);
    check("rst retry mem_en cycles", en_cnt, 32'd3);
    check("rst retry addr", {16'd0, bus.mem_addr}, 32'h0300);
    check("rst retry dma_rdata", {16'd0, bus.dma_rdata}, 32'h0000);
    idle_inputs();
    step();
    step();

    // cpu_req dropped during ACCESS: the access still completes once.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0040;
    step();
    check("drop grant", {31'd0, bus.mem_en}, 32'd1);
    bus.cpu_req = 1'b0;
    ack_cnt = 0;
    en_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.cpu_ack) ack_cnt++;
      if (bus.mem_en) en_cnt++;
    end
    check("drop ack count", ack_cnt, 32'd1);
    check("drop mem_en cycles", en_cnt, 32'd2);
    check("drop cpu_rdata", {16'd0, bus.cpu_rdata}, 32'hC250);
    check("drop idle mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("drop dma_ack", {31'd0, bus.dma_ack}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between two requesters: the CPU MAR/MDR path driven by the controller, and a DMA/IO requester.
- Arbitrates between them round-robin and sequences each access through a fixed number of wait cycles.
- Returns read data and a one-cycle acknowledge to the winning requester.
- Sits between the requesters and the memory block; it is the only block that drives the memory control and address lines.

Parameters:
- AW, 16, address width.
- DW, 16, data width (matches the ISR/MDR width).
- WAIT, 2, extra memory cycles per access beyond the first; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  CPU access type: 1=write, 0=read.
- cpu_addr  in  AW  CPU address; stable while cpu_req is high.
- cpu_wdata  in  DW  CPU write data; stable while cpu_req is high.
- cpu_ack  out  1  one-cycle pulse when the CPU access has completed.
- cpu_rdata  out  DW  registered read data for the CPU; valid from cpu_ack until the next CPU read completes.
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata: same as the cpu_* ports, for the DMA requester.
- mem_en  out  1  memory enable; high for the whole access.
- mem_rw  out  1  memory direction: 1=write, 0=read.
- mem_addr  out  AW  registered memory address.
- mem_wdata  out  DW  registered memory write data.
- mem_rdata  in  DW  memory read data; valid in the last ACCESS cycle.
- grant_dma  out  1  status: 1 while the DMA owns the port (ACCESS/RESP), 0 otherwise.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, last=DMA.
  - All outputs 0, including both rdata registers.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE; mem_en=0.
  - Exactly one req high: grant that requester.
  - Both high: grant the requester that is not `last`. After reset this makes the CPU win the first tie.
  - On grant:
    - latch we/addr/wdata into mem_rw/mem_addr/mem_wdata;
    - set mem_en=1, cnt=WAIT, last=winner;
    - set grant_dma accordingly;
    - go to ACCESS.
- ACCESS:
  - mem_en, mem_rw, mem_addr and mem_wdata are held constant.
  - cnt!=0: cnt decrements.
  - cnt==0:
    - on a read, capture mem_rdata into the winner's rdata register (the other rdata register is untouched);
    - mem_en=0, mem_rw=0;
    - winner's ack=1;
    - go to RESP.
  - Total mem_en high time is exactly WAIT+1 cycles.
- RESP:
  - The ack is high for exactly this one cycle.
  - Next edge: ack=0, grant_dma=0, go to IDLE.
- Latency:
  - Request sampled at edge k: ack is high in the cycle following edge k+WAIT+1, i.e. WAIT+2 cycles after sampling.
  - The next grant is possible at the edge ending RESP+IDLE. Minimum spacing between grants is WAIT+3 cycles.
- Requester rule:
  - The requester drops req in the cycle after ack, or keeps it high to request again. A held req is re-arbitrated in IDLE as a new access.
- req dropped during ACCESS: the access still completes; ack still pulses; the write still occurs.
- req of the loser changing while the other requester is granted: ignored until IDLE.
- WAIT=0: a single ACCESS cycle; ack follows after 2 cycles.
- Writes leave the rdata registers unchanged.
- Reset mid-access: immediate return to IDLE with all outputs 0; no ack is issued; the aborted access is not retried.
- Continuous contention: strict alternation (CPU, DMA, CPU, ...); neither requester can starve.

Decomposition:
- Shared package:
  - state encodings IDLE/ACCESS/RESP;
  - requester IDs REQ_CPU=0, REQ_DMA=1;
  - the mem_rw encoding WRITE=1/READ=0, shared with the controller's mrw meaning.
- Sub-module: one natural sub-module, rr_pick, a combinational 2-way round-robin picker. Inputs: cpu_req, dma_req, last. Outputs: grant valid, winner.
- The wait counter and FSM stay in mem_arbiter.

Test Plan:
- Reset then CPU read, WAIT=2: cpu_req=1, cpu_we=0, cpu_addr=16'h0010, mem_rdata=16'hC200 → mem_en high 3 cycles with mem_addr=16'h0010, mem_rw=0; cpu_ack pulses 4 cycles after sampling; cpu_rdata=16'hC200; dma_ack never asserts.
- DMA write: dma_we=1, dma_addr=16'h0100, dma_wdata=16'hBEEF → mem_rw=1 and mem_wdata=16'hBEEF for 3 cycles; grant_dma=1 through RESP; dma_rdata unchanged (0).
- Simultaneous requests held high for 4 accesses right after reset → grant order CPU, DMA, CPU, DMA; each ack is a single-cycle pulse; mem_addr matches the owner each time.
- WAIT=0 build: back-to-back CPU reads with cpu_req held → mem_en 1 cycle per access; cpu_ack every 3 cycles.
- reset asserted low during the 2nd ACCESS cycle of a DMA write → all outputs 0 immediately; no dma_ack. After release with dma_req still high, a fresh 3-cycle access completes with dma_ack.
- cpu_req dropped during ACCESS → the access completes; cpu_ack pulses once; FSM returns to IDLE and stays there with mem_en=0.
